// File: rtl/sprite_tx.sv
// Serializes a 14-bit {command, data} word onto a clock/strobe/data sprite link,
// MSB first, followed by an idle gap before the next word is accepted.
module sprite_tx #(
    parameter int unsigned HALF_PERIOD = 4,
    parameter int unsigned GAP_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [3:0] tx_command,
    input  logic [9:0] tx_data,
    output logic       spr_clk,
    output logic       spr_cmd,
    output logic       spr_ser,
    output logic       tx_done
);

    localparam int unsigned WORD_W = 14;
    localparam int unsigned PH_W   = 8;
    localparam int unsigned BIT_W  = 4;

    localparam logic [PH_W-1:0]  PH_HALF = PH_W'(HALF_PERIOD - 1);
    localparam logic [PH_W-1:0]  PH_GAP  = PH_W'(GAP_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(WORD_W - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_HIGH  = 3'd2;
    localparam logic [2:0] S_LOW   = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]        state, state_n;
    logic [PH_W-1:0]   phase, phase_n;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [WORD_W-1:0] word, word_n;
    logic              tx_ready_n, tx_done_n;
    logic              spr_clk_n, spr_cmd_n, spr_ser_n;
    logic              accept_c;

    assign accept_c = tx_valid & tx_ready;

    // Next state/counters, then outputs derived from the state being entered so they register cleanly.
    always_comb begin
        state_n   = state;
        phase_n   = phase;
        bit_cnt_n = bit_cnt;
        word_n    = word;

        case (state)
            S_IDLE: begin
                if (accept_c) begin
                    state_n   = S_SETUP;
                    word_n    = {tx_command, tx_data};
                    phase_n   = PH_HALF;
                    bit_cnt_n = BIT_TOP;
                end
            end
            S_SETUP: begin
                if (phase == '0) begin
                    state_n = S_HIGH;
                    phase_n = PH_HALF;
                end else begin
                    phase_n = phase - 1'b1;
                end
            end
            S_HIGH: begin
                if (phase != '0) begin
                    phase_n = phase - 1'b1;
                end else if (bit_cnt == '0) begin
                    state_n = S_GAP;
                    phase_n = PH_GAP;
                end else begin
                    state_n   = S_LOW;
                    phase_n   = PH_HALF;
                    bit_cnt_n = bit_cnt - 1'b1;
                end
            end
            S_LOW: begin
                if (phase == '0) begin
                    state_n = S_HIGH;
                    phase_n = PH_HALF;
                end else begin
                    phase_n = phase - 1'b1;
                end
            end
            S_GAP: begin
                if (phase == '0) begin
                    state_n = S_IDLE;
                end else begin
                    phase_n = phase - 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        spr_cmd_n  = (state_n == S_SETUP) || (state_n == S_HIGH) || (state_n == S_LOW);
        spr_clk_n  = (state_n == S_HIGH);
        spr_ser_n  = spr_cmd_n ? word_n[bit_cnt_n] : 1'b0;
        tx_ready_n = (state_n == S_IDLE);
        tx_done_n  = (state_n == S_GAP) && (phase_n == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            phase    <= '0;
            bit_cnt  <= '0;
            word     <= '0;
            tx_ready <= 1'b1;
            tx_done  <= 1'b0;
            spr_clk  <= 1'b0;
            spr_cmd  <= 1'b0;
            spr_ser  <= 1'b0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            bit_cnt  <= bit_cnt_n;
            word     <= word_n;
            tx_ready <= tx_ready_n;
            tx_done  <= tx_done_n;
            spr_clk  <= spr_clk_n;
            spr_cmd  <= spr_cmd_n;
            spr_ser  <= spr_ser_n;
        end
    end

endmodule
